spr_capture: RTL

SPR_CAPTURE -- requirements
Module: spr_capture

---
 rtl/spr_capture.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spr_capture.sv
// spr_capture: copies a CAP_WIDTH x CAP_HEIGHT window of the incoming
// pixel stream into a bitmap RAM. The RAM is written in row-major order.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   en            capture enable; low freezes the FSM and blocks writes
//   frame, line   one-cycle start-of-frame / start-of-active-line pulses
//   sx, sy        signed screen position of pix_in
//   capx, capy    signed top-left corner of the window; sampled when the
//                 capture frame starts
//   pix_in        pixel at (sx, sy)
//   arm           request a capture of the next full frame
//   wr_en/wr_addr/wr_data   bitmap RAM write port; one cycle after the pixel
//   busy          high from arm acceptance until done
//   done          one-cycle completion pulse
//   partial       valid with done; 1 = at least one location was not written
module spr_capture #(
   parameter  int CORDW      = 10,
   parameter  int CAP_WIDTH  = 8,
   parameter  int CAP_HEIGHT = 8,
   parameter  int CAP_DATAW  = 3,
   localparam int CAP_DEPTH  = CAP_WIDTH * CAP_HEIGHT,
   localparam int AW         = $clog2(CAP_DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        frame,
   input  logic                        line,
   input  logic signed [CORDW-1:0]     sx,
   input  logic signed [CORDW-1:0]     sy,
   input  logic signed [CORDW-1:0]     capx,
   input  logic signed [CORDW-1:0]     capy,
   input  logic        [CAP_DATAW-1:0] pix_in,
   input  logic                        arm,
   output logic                        wr_en,
   output logic        [AW-1:0]        wr_addr,
   output logic        [CAP_DATAW-1:0] wr_data,
   output logic                        busy,
   output logic                        done,
   output logic                        partial
);

   localparam int CW = $clog2(CAP_WIDTH);
   localparam logic signed [CORDW:0] W_S      = (CORDW+1)'(CAP_WIDTH);
   localparam logic signed [CORDW:0] H_S      = (CORDW+1)'(CAP_HEIGHT);
   localparam logic signed [CORDW:0] COL_LAST = (CORDW+1)'(CAP_WIDTH - 1);
   localparam logic signed [CORDW:0] ROW_LAST = (CORDW+1)'(CAP_HEIGHT - 1);
   localparam logic        [AW:0]    DEPTH_C  = (AW+1)'(CAP_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_WAIT_LINE,
      S_CAPTURE,
      S_FIN
   } state_t;

   state_t                  state_q, state_d;
   logic signed [CORDW-1:0] capx_q, capx_d;
   logic signed [CORDW-1:0] capy_q, capy_d;
   logic                    miss_q, miss_d;
   logic        [AW:0]      cnt_q, cnt_d;
   logic                    wr_en_q, wr_en_d;
   logic        [AW-1:0]    wr_addr_q, wr_addr_d;
   logic [CAP_DATAW-1:0]    wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    partial_q, partial_d;

   logic signed [CORDW:0]   row, col;
   logic                    row_in, in_win;

   always_comb begin
      // One extra bit so the difference of two CORDW-bit values cannot wrap.
      row    = {sy[CORDW-1], sy} - {capy_q[CORDW-1], capy_q};
      col    = {sx[CORDW-1], sx} - {capx_q[CORDW-1], capx_q};
      row_in = !row[CORDW] && (row < H_S);
      in_win = row_in && !col[CORDW] && (col < W_S);

      state_d   = state_q;
      capx_d    = capx_q;
      capy_d    = capy_q;
      miss_d    = miss_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      partial_d = 1'b0;

      if (en) begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_d = S_ARMED;
                  busy_d  = 1'b1;
                  miss_d  = 1'b0;
                  cnt_d   = '0;
               end
            end
            S_ARMED: begin
               if (frame) begin
                  capx_d  = capx;
                  capy_d  = capy;
                  state_d = S_WAIT_LINE;
               end
            end
            S_WAIT_LINE: begin
               if (frame) begin
                  miss_d  = 1'b1;
                  state_d = S_FIN;
               end else if (line && row_in) begin
                  state_d = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (frame) begin
                  miss_d  = 1'b1;
                  state_d = S_FIN;
               end else if (line) begin
                  // Still in CAPTURE means the right edge was never written.
                  miss_d  = 1'b1;
                  state_d = row_in ? S_CAPTURE : S_WAIT_LINE;
               end else if (in_win) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = (AW'(row) << CW) + AW'(col);
                  wr_data_d = pix_in;
                  cnt_d     = cnt_q + (AW+1)'(1);
                  if (col == COL_LAST)
                     state_d = (row == ROW_LAST) ? S_FIN : S_WAIT_LINE;
               end
            end
            S_FIN: begin
               // The write count also catches rows and columns that lay off-screen.
               done_d    = 1'b1;
               partial_d = miss_q || (cnt_q != DEPTH_C);
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q == S_CAPTURE && in_win) begin
         miss_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         capx_q    <= '0;
         capy_q    <= '0;
         miss_q    <= 1'b0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         partial_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         capx_q    <= capx_d;
         capy_q    <= capy_d;
         miss_q    <= miss_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         partial_q <= partial_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign partial = partial_q;

endmodule
